gray_binary_conv_pipe: RTL and testbench
========================================

Name: gray_binary_conv_pipe

Overview:
Parametrised, pipelined, bidirectional Gray/binary code converter with valid/ready flow control.
- Each accepted beat carries a mode bit that selects Gray-to-binary or binary-to-Gray conversion, plus a pass-through tag.
- The serial XOR chain of the Gray-to-binary direction is split across `stages` register stages, so wide words meet timing.
- Sits between producers and consumers of Gray-coded pointers and counters, e.g. async FIFO pointer decode or encoder readout.

Parameters:
- data_width, 4, bits per converted word (>=2).
- stages, 2, pipeline register stages, equal to the latency in cycles (1..data_width).
- tag_width, 4, sideband tag bits carried alongside each beat (>=1).

Ports:
- clk  input  1  clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_mode  input  1  0 = Gray-to-binary, 1 = binary-to-Gray.
- d_in  input  data_width  word to convert.
- tag_in  input  tag_width  sideband, returned unchanged.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the output beat.
- d_out  output  data_width  converted word.
- tag_out  output  tag_width  tag of the beat on d_out.
- mode_out  output  1  mode of the beat on d_out.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: all stage valid bits, out_valid, d_out, tag_out and mode_out are 0. in_ready follows its equation below, so it reads 1 during and after reset.
- Reset mid-operation: every in-flight beat is discarded, with no partial output. The first beat accepted after rst deasserts appears exactly `stages` cycles after acceptance.
- Pipeline enable: en = out_ready | ~out_valid. in_ready = en, combinational and free of any in_valid dependency.
- Stall: when en = 0 every stage holds its contents, including valid bits. No beat is dropped or duplicated.
- Acceptance: a beat is accepted when in_valid & in_ready.
- Advance: when en = 1 all stages shift one place. Stage 0 loads valid = in_valid & in_ready together with the data, mode and tag.
  - Bubbles propagate as valid = 0.
  - Bubbles are not collapsed while stalled.
- Latency: exactly `stages` cycles from acceptance to out_valid with no stall; each stall cycle adds one cycle. Throughput is one beat per cycle when out_ready = 1.
- Gray-to-binary:
  - b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i].
  - The chain is partitioned MSB-first into `stages` segments of ceil(data_width/stages) bits; the last segment takes the remainder and may be empty.
  - Stage k resolves segment k, using the resolved LSB of segment k-1 carried in its register.
  - Unresolved raw bits travel in the same stage register.
- Binary-to-Gray: g = b ^ (b >> 1), computed in stage 0 and carried unchanged through the remaining stages.
- Ordering: the mode can differ on every beat. Output order equals acceptance order regardless of mode.
- stages = 1: fully combinational chain into a single register. Latency 1.
- stages = data_width: one bit resolved per stage.
- Simultaneous events:
  - Acceptance and output handoff in the same cycle are both legal and required for full throughput.
  - in_valid asserted during reset is ignored.
- d_out, tag_out and mode_out are don't-care when out_valid = 0, but must be held stable while out_valid & ~out_ready.

Test Plan:
- data_width=4, stages=2: accept gray 4'b1101, mode 0, tag 3 -> two cycles later out_valid=1, d_out=4'b1001, tag_out=3, mode_out=0.
- data_width=4: back-to-back beats, out_ready=1: binary 4'b1001 mode 1, then gray 4'b1101 mode 0 -> consecutive outputs 4'b1101 then 4'b1001; in_ready stays 1 throughout.
- data_width=8, stages=3: gray 8'hFF -> 8'hAA; binary 8'hFF -> 8'h80; gray 8'h00 -> 8'h00.
- Backpressure: out_ready=0 for 5 cycles with 3 beats in flight -> out_valid and d_out held stable and in_ready=0; after release the 3 beats emerge in order with no loss or duplication.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid drops to 0 immediately (asynchronous); after release a new beat emerges after exactly `stages` cycles and no stale beat appears.
- Exhaustive round-trip, data_width=6, stages in {1, 3, 6}: every value converted binary-to-Gray then Gray-to-binary -> equals the original; each adjacent binary pair yields Gray codes differing in exactly one bit.

Source files
------------

// File: rtl/gray_binary_conv_pipe.sv
// ---------------------------------------------------------------------------
// gray_binary_conv_pipe
//
// Pipelined, bidirectional Gray/binary converter with valid/ready handshake.
// Each beat picks its own direction through in_mode:
//   in_mode = 0 : Gray-to-binary. The serial XOR chain is cut into `stages`
//                 MSB-first segments of ceil(data_width/stages) bits. Each
//                 stage register resolves one segment.
//   in_mode = 1 : binary-to-Gray. The result is finished in stage 0 and then
//                 carried unchanged to the output.
// The latency is `stages` cycles. The whole pipe freezes when the output is
// valid and not accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   pipe can take a beat (= out_ready | ~out_valid)
//   in_mode    0 = Gray->binary, 1 = binary->Gray
//   d_in       word to convert
//   tag_in     sideband returned unchanged with the beat
//   out_valid  output beat valid
//   out_ready  consumer accepts the output beat
//   d_out      converted word
//   tag_out    tag of the beat on d_out
//   mode_out   mode of the beat on d_out
// ---------------------------------------------------------------------------
module gray_binary_conv_pipe #(
   parameter int data_width = 4,
   parameter int stages     = 2,
   parameter int tag_width  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [data_width-1:0] d_in,
   input  logic [tag_width-1:0]  tag_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [data_width-1:0] d_out,
   output logic [tag_width-1:0]  tag_out,
   output logic                  mode_out
);

   // Bits resolved per stage. When the split is uneven, the last segment is
   // short. If stages does not divide the width evenly enough, the last
   // segment can also be empty.
   localparam int seg_w = (data_width + stages - 1) / stages;

   logic [data_width-1:0] word_p [stages];
   logic [tag_width-1:0]  tag_p  [stages];
   logic                  mode_p [stages];
   logic                  vld_p  [stages];
   logic                  en;

   // Resolve segment k of a partly decoded Gray word. Bits above the segment
   // are already binary. Bits below it are still raw Gray. The MSB-first walk
   // means r[i+1] is already resolved when bit i is computed.
   function automatic logic [data_width-1:0] g2b_seg(
      input logic [data_width-1:0] w,
      input int                    k
   );
      logic [data_width-1:0] r;
      int                    hi;
      int                    lo;
      r  = w;
      hi = data_width - 1 - k * seg_w;
      lo = data_width - (k + 1) * seg_w;
      for (int i = data_width - 2; i >= 0; i--) begin
         if (i <= hi && i >= lo) r[i] = r[i+1] ^ w[i];
      end
      return r;
   endfunction

   function automatic logic [data_width-1:0] b2g(input logic [data_width-1:0] w);
      return w ^ (w >> 1);
   endfunction

   // The handshake is combinational. It never looks at in_valid.
   assign en        = out_ready | ~out_valid;
   assign in_ready  = en;
   assign out_valid = vld_p[stages-1];
   assign d_out     = word_p[stages-1];
   assign tag_out   = tag_p[stages-1];
   assign mode_out  = mode_p[stages-1];

   // Reset clears data as well as valids, so the outputs read 0 during and
   // after reset. While en is low, every stage holds its contents, bubbles
   // included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < stages; k++) begin
            vld_p[k]  <= 1'b0;
            word_p[k] <= '0;
            tag_p[k]  <= '0;
            mode_p[k] <= 1'b0;
         end
      end else if (en) begin
         // stage 0: accept, finish binary->Gray or resolve Gray segment 0
         vld_p[0]  <= in_valid;
         word_p[0] <= in_mode ? b2g(d_in) : g2b_seg(d_in, 0);
         mode_p[0] <= in_mode;
         tag_p[0]  <= tag_in;
         // stage k: resolve Gray segment k, or carry a finished Gray word
         for (int k = 1; k < stages; k++) begin
            vld_p[k]  <= vld_p[k-1];
            word_p[k] <= mode_p[k-1] ? word_p[k-1] : g2b_seg(word_p[k-1], k);
            mode_p[k] <= mode_p[k-1];
            tag_p[k]  <= tag_p[k-1];
         end
      end
   end

endmodule

// File: tb/tb_gray_binary_conv_pipe.sv
// ---------------------------------------------------------------------------
// tb_gray_binary_conv_pipe
//
// Five independent instances, each with its own reset and handshake:
//   cfg[0] : data_width 4, stages 2 - basic beats, back-to-back, reset mid-stream
//   cfg[1] : data_width 8, stages 3 - directed words, 5-cycle backpressure
//   cfg[2..4] : data_width 6, stages 1/3/6 - exhaustive round trip
// Accepted beats push their hand-computed expectation into a per-instance
// queue. A monitor pops the queue and compares on every output handoff.
// ---------------------------------------------------------------------------
module tb_gray_binary_conv_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   for (genvar g = 0; g < 5; g++) begin : cfg
      localparam int DW = (g == 0) ? 4 : (g == 1) ? 8 : 6;
      localparam int ST = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : (g == 3) ? 3 : 6;

      logic          rst;
      logic          in_valid;
      logic          in_ready;
      logic          in_mode;
      logic [DW-1:0] d_in;
      logic [3:0]    tag_in;
      logic          out_valid;
      logic          out_ready;
      logic [DW-1:0] d_out;
      logic [3:0]    tag_out;
      logic          mode_out;

      logic [7:0]    exp_d;
      logic          exp_chk;
      logic [13:0]   sb [$];    // {chk, d[7:0], tag[3:0], mode}
      logic [DW-1:0] cap [$];   // outputs of unchecked (chk=0) beats
      logic [13:0]   em;
      bit            done = 1'b0;

      gray_binary_conv_pipe #(.data_width(DW), .stages(ST), .tag_width(4)) dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
         .in_mode(in_mode), .d_in(d_in), .tag_in(tag_in), .out_valid(out_valid),
         .out_ready(out_ready), .d_out(d_out), .tag_out(tag_out), .mode_out(mode_out)
      );

      // Push the expectation of a beat that is accepted on this edge.
      always @(posedge clk) begin
         if (!rst && in_valid && in_ready)
            sb.push_back({exp_chk, exp_d, tag_in, in_mode});
      end

      // Compare every output beat that is handed off on the next edge.
      always @(negedge clk) begin
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL cfg%0d unexpected beat: got d_out=%0h tag=%0h, required no beat", g, d_out, tag_out);
            end else begin
               em = sb.pop_front();
               check($sformatf("cfg%0d tag_out", g), 32'(tag_out), 32'(em[4:1]));
               check($sformatf("cfg%0d mode_out", g), 32'(mode_out), 32'(em[0]));
               if (em[13]) check($sformatf("cfg%0d d_out", g), 32'(d_out), 32'(em[12:5]));
               else cap.push_back(d_out);
            end
         end
      end

      task automatic send(input logic [7:0] d, input logic m, input logic [3:0] t,
                          input logic [7:0] ed, input logic c, output int w);
         logic ok;
         in_valid = 1'b1;
         d_in     = d[DW-1:0];
         in_mode  = m;
         tag_in   = t;
         exp_d    = ed;
         exp_chk  = c;
         w        = 0;
         ok       = 1'b0;
         while (!ok && w < 200) begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (!ok) w++;
         end
         in_valid = 1'b0;
         if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cfg%0d send timeout: got in_ready=0 for 200 cycles, required acceptance", g);
         end
      endtask

      // Call this right after send() returns. The acceptance cycle counts as 1.
      task automatic lat_check(input int req);
         int n;
         n = 0;
         while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
         end
         check($sformatf("cfg%0d latency", g), 32'(n + 1), 32'(req));
      endtask

      task automatic reset_seq();
         rst       = 1'b1;
         in_valid  = 1'b0;
         in_mode   = 1'b0;
         d_in      = '0;
         tag_in    = '0;
         out_ready = 1'b0;
         exp_d     = '0;
         exp_chk   = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         check($sformatf("cfg%0d reset out_valid", g), 32'(out_valid), 32'd0);
         check($sformatf("cfg%0d reset in_ready", g), 32'(in_ready), 32'd1);
         check($sformatf("cfg%0d reset d_out", g), 32'(d_out), 32'd0);
         check($sformatf("cfg%0d reset tag/mode", g), 32'({tag_out, mode_out}), 32'd0);
         rst = 1'b0;
      endtask

      task automatic drain();
         repeat (ST + 4) @(posedge clk);
         #1;
      endtask

      if (g == 0) begin : t_basic
         initial begin
            int w0, w1;
            reset_seq();
            out_ready = 1'b1;
            send(8'h0D, 1'b0, 4'd3, 8'h09, 1'b1, w0);      // gray 1101 -> 1001
            lat_check(2);
            drain();
            send(8'h09, 1'b1, 4'd5, 8'h0D, 1'b1, w0);      // bin 1001 -> 1101
            send(8'h0D, 1'b0, 4'd6, 8'h09, 1'b1, w1);      // gray 1101 -> 1001
            check("cfg0 back-to-back in_ready wait 1", 32'(w0), 32'd0);
            check("cfg0 back-to-back in_ready wait 2", 32'(w1), 32'd0);
            drain();
            // Put two beats in flight, then reset in the middle of a cycle.
            out_ready = 1'b0;
            send(8'h03, 1'b0, 4'd7, 8'h02, 1'b1, w0);
            send(8'h03, 1'b1, 4'd8, 8'h02, 1'b1, w0);
            #1 rst = 1'b1;
            #1 check("cfg0 async reset out_valid", 32'(out_valid), 32'd0);
            sb.delete();
            in_valid = 1'b1;                             // must be ignored
            d_in     = 4'hF;
            repeat (2) @(posedge clk);
            #1;
            in_valid  = 1'b0;
            rst       = 1'b0;
            out_ready = 1'b1;
            repeat (3) begin
               @(posedge clk);
               #1;
               check("cfg0 no stale beat after reset", 32'(out_valid), 32'd0);
            end
            send(8'h06, 1'b0, 4'd9, 8'h04, 1'b1, w0);      // gray 0110 -> 0100
            lat_check(2);
            drain();
            check("cfg0 scoreboard empty", 32'(sb.size()), 32'd0);
            done = 1'b1;
         end
      end else if (g == 1) begin : t_bp
         initial begin
            int w;
            reset_seq();
            out_ready = 1'b1;
            send(8'hFF, 1'b0, 4'd1, 8'hAA, 1'b1, w);
            lat_check(3);
            send(8'hFF, 1'b1, 4'd2, 8'h80, 1'b1, w);
            send(8'h00, 1'b0, 4'd3, 8'h00, 1'b1, w);
            send(8'h80, 1'b0, 4'd4, 8'hFF, 1'b1, w);
            send(8'h01, 1'b0, 4'd5, 8'h01, 1'b1, w);
            send(8'hAA, 1'b1, 4'd6, 8'hFF, 1'b1, w);
            drain();
            // Fill all three stages while the output is blocked.
            out_ready = 1'b0;
            send(8'h12, 1'b1, 4'd4, 8'h1B, 1'b1, w);
            send(8'h34, 1'b0, 4'd5, 8'h27, 1'b1, w);
            send(8'h56, 1'b1, 4'd6, 8'h7D, 1'b1, w);
            repeat (5) begin
               check("cfg1 stall out_valid", 32'(out_valid), 32'd1);
               check("cfg1 stall d_out held", 32'(d_out), 32'h1B);
               check("cfg1 stall tag_out held", 32'(tag_out), 32'd4);
               check("cfg1 stall in_ready", 32'(in_ready), 32'd0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
            drain();
            check("cfg1 scoreboard empty", 32'(sb.size()), 32'd0);
            done = 1'b1;
         end
      end else begin : t_rt
         initial begin
            int w;
            reset_seq();
            out_ready = 1'b1;
            send(8'd0, 1'b1, 4'd0, 8'd0, 1'b0, w);
            lat_check(ST);
            for (int v = 1; v < 64; v++) send(8'(v), 1'b1, 4'(v), 8'd0, 1'b0, w);
            drain();
            check($sformatf("cfg%0d gray count", g), 32'(cap.size()), 32'd64);
            if (cap.size() > 0) check($sformatf("cfg%0d gray of 0", g), 32'(cap[0]), 32'd0);
            for (int v = 0; v < cap.size(); v++)
               send(8'(cap[v]), 1'b0, 4'(v), 8'(v), 1'b1, w);
            drain();
            check($sformatf("cfg%0d scoreboard empty", g), 32'(sb.size()), 32'd0);
            for (int v = 0; v + 1 < cap.size(); v++)
               check($sformatf("cfg%0d adjacent gray distance %0d", g, v),
                     32'($countones(cap[v] ^ cap[v+1])), 32'd1);
            done = 1'b1;
         end
      end
   end

   initial begin
      bit all_done;
      all_done = 1'b0;
      for (int i = 0; i < 20000 && !all_done; i++) begin
         @(posedge clk);
         all_done = cfg[0].done & cfg[1].done & cfg[2].done & cfg[3].done & cfg[4].done;
      end
      if (!all_done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL global timeout: got unfinished sequences, required all done");
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
